// File: rtl/sha2_sigma_cfu.sv
// rtl/sha2_sigma_cfu.sv - pipelined SHA-2 Sum0/Sum1/sigma0/sigma1 custom-function unit
// Optional performance counters: define SHA2_SIGMA_CFU_PERF_EN.
module sha2_sigma_cfu #(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 1,
  parameter int ID_W        = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_func,
  input  logic [XLEN-1:0] req_data0,
  input  logic [ID_W-1:0] req_id,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [ID_W-1:0] resp_id,
  output logic            busy
`ifdef SHA2_SIGMA_CFU_PERF_EN
  ,
  output logic [31:0]     perf_req_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("sha2_sigma_cfu: XLEN must be 32 or 64");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
      $error("sha2_sigma_cfu: PIPE_STAGES must be 1..3");
    end
  endgenerate

  localparam bit W64 = (XLEN == 64);

  localparam int S0_A = W64 ? 28 : 2;
  localparam int S0_B = W64 ? 34 : 13;
  localparam int S0_C = W64 ? 39 : 22;
  localparam int S1_A = W64 ? 14 : 6;
  localparam int S1_B = W64 ? 18 : 11;
  localparam int S1_C = W64 ? 41 : 25;
  localparam int G0_A = W64 ? 1  : 7;
  localparam int G0_B = W64 ? 8  : 18;
  localparam int G0_C = W64 ? 7  : 3;
  localparam int G1_A = W64 ? 19 : 17;
  localparam int G1_B = W64 ? 61 : 19;
  localparam int G1_C = W64 ? 6  : 10;

  function automatic logic [XLEN-1:0] ror(input logic [XLEN-1:0] x, input int n);
    return (x >> n) | (x << (XLEN - n));
  endfunction

  logic                  stall;
  logic                  accept;
  logic                  run_q;
  logic [XLEN-1:0]       f_result;
  logic [PIPE_STAGES-1:0] st_valid;
  logic [XLEN-1:0]       st_data [PIPE_STAGES];
  logic [ID_W-1:0]       st_id   [PIPE_STAGES];

  assign resp_valid = st_valid[PIPE_STAGES-1];
  assign resp_data  = st_data[PIPE_STAGES-1];
  assign resp_id    = st_id[PIPE_STAGES-1];
  assign busy       = |st_valid;
  assign stall      = resp_valid && !resp_ready;
  assign req_ready  = run_q && !stall;
  assign accept     = req_valid && req_ready;

  always_comb begin
    f_result = '0;
    case (req_func)
      2'd0:    f_result = ror(req_data0, S0_A) ^ ror(req_data0, S0_B) ^ ror(req_data0, S0_C);
      2'd1:    f_result = ror(req_data0, S1_A) ^ ror(req_data0, S1_B) ^ ror(req_data0, S1_C);
      2'd2:    f_result = ror(req_data0, G0_A) ^ ror(req_data0, G0_B) ^ (req_data0 >> G0_C);
      default: f_result = ror(req_data0, G1_A) ^ ror(req_data0, G1_B) ^ (req_data0 >> G1_C);
    endcase
  end

  // Keeps req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Whole pipe advances together; any stall freezes every stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_valid <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        st_data[k] <= '0;
        st_id[k]   <= '0;
      end
    end else if (!stall) begin
      st_valid[0] <= accept;
      if (accept) begin
        st_data[0] <= f_result;
        st_id[0]   <= req_id;
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        st_valid[k] <= st_valid[k-1];
        st_data[k]  <= st_data[k-1];
        st_id[k]    <= st_id[k-1];
      end
    end
  end

`ifdef SHA2_SIGMA_CFU_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_req_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (accept) perf_req_cnt <= perf_req_cnt + 32'd1;
      if (stall)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha2_sigma_cfu.sv
// tb/tb_sha2_sigma_cfu.sv - directed checks of sha2_sigma_cfu in 32/64-bit, 1/2/3-stage builds
module tb_sha2_sigma_cfu;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // a: XLEN=32, 1 stage
  logic        a_req_valid = 0, a_req_ready, a_resp_valid, a_resp_ready = 0, a_busy;
  logic [1:0]  a_req_func = 0;
  logic [31:0] a_req_data0 = 0, a_resp_data;
  logic [3:0]  a_req_id = 0, a_resp_id;
  // b: XLEN=32, 3 stages
  logic        b_req_valid = 0, b_req_ready, b_resp_valid, b_resp_ready = 0, b_busy;
  logic [1:0]  b_req_func = 0;
  logic [31:0] b_req_data0 = 0, b_resp_data;
  logic [3:0]  b_req_id = 0, b_resp_id;
  // c: XLEN=64, 2 stages
  logic        c_req_valid = 0, c_req_ready, c_resp_valid, c_resp_ready = 0, c_busy;
  logic [1:0]  c_req_func = 0;
  logic [63:0] c_req_data0 = 0, c_resp_data;
  logic [3:0]  c_req_id = 0, c_resp_id;
`ifdef SHA2_SIGMA_CFU_PERF_EN
  logic [31:0] a_perf_req, a_perf_stall, b_perf_req, b_perf_stall, c_perf_req, c_perf_stall;
`endif

  sha2_sigma_cfu #(.XLEN(32), .PIPE_STAGES(1), .ID_W(4)) u_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_func(a_req_func), .req_data0(a_req_data0), .req_id(a_req_id),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_data(a_resp_data),
    .resp_id(a_resp_id), .busy(a_busy)
`ifdef SHA2_SIGMA_CFU_PERF_EN
    , .perf_req_cnt(a_perf_req), .perf_stall_cnt(a_perf_stall)
`endif
  );

  sha2_sigma_cfu #(.XLEN(32), .PIPE_STAGES(3), .ID_W(4)) u_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_func(b_req_func), .req_data0(b_req_data0), .req_id(b_req_id),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data),
    .resp_id(b_resp_id), .busy(b_busy)
`ifdef SHA2_SIGMA_CFU_PERF_EN
    , .perf_req_cnt(b_perf_req), .perf_stall_cnt(b_perf_stall)
`endif
  );

  sha2_sigma_cfu #(.XLEN(64), .PIPE_STAGES(2), .ID_W(4)) u_c (
    .clk(clk), .rst(rst), .req_valid(c_req_valid), .req_ready(c_req_ready),
    .req_func(c_req_func), .req_data0(c_req_data0), .req_id(c_req_id),
    .resp_valid(c_resp_valid), .resp_ready(c_resp_ready), .resp_data(c_resp_data),
    .resp_id(c_resp_id), .busy(c_busy)
`ifdef SHA2_SIGMA_CFU_PERF_EN
    , .perf_req_cnt(c_perf_req), .perf_stall_cnt(c_perf_stall)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic a_issue(input logic [1:0] f, input logic [31:0] d, input logic [3:0] id);
    a_req_valid = 1'b1; a_req_func = f; a_req_data0 = d; a_req_id = id;
  endtask

  task automatic b_issue(input logic [1:0] f, input logic [31:0] d, input logic [3:0] id);
    b_req_valid = 1'b1; b_req_func = f; b_req_data0 = d; b_req_id = id;
  endtask

  logic [1:0]  bf [5];
  logic [31:0] bd [5];
  logic [31:0] be [5];

  initial begin
    bf[0] = 2'd0; bd[0] = 32'h6a09e667; be[0] = 32'hce20b47e;
    bf[1] = 2'd1; bd[1] = 32'h510e527f; be[1] = 32'h3587272b;
    bf[2] = 2'd2; bd[2] = 32'h00000001; be[2] = 32'h02004000;
    bf[3] = 2'd3; bd[3] = 32'h00000001; be[3] = 32'h0000a000;
    bf[4] = 2'd2; bd[4] = 32'h00000002; be[4] = 32'h04008000;

    // reset state
    @(negedge clk);
    chk("rst_resp_valid", a_resp_valid, 0);
    chk("rst_busy", b_busy, 0);
    chk("rst_resp_data", b_resp_data, 0);
    chk("rst_resp_id", b_resp_id, 0);
    chk("rst_req_ready", a_req_ready, 0);
`ifdef SHA2_SIGMA_CFU_PERF_EN
    chk("rst_perf_req", b_perf_req, 0);
    chk("rst_perf_stall", b_perf_stall, 0);
`endif
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", a_req_ready, 1);
    chk("post_rst_req_ready_b", b_req_ready, 1);

    // a: single stage, back-to-back
    a_resp_ready = 1'b1;
    a_issue(2'd0, 32'h6a09e667, 4'd3);
    @(negedge clk);
    chk("a_lat_valid", a_resp_valid, 1);
    chk("a_sum0", a_resp_data, 32'hce20b47e);
    chk("a_sum0_id", a_resp_id, 3);
    a_issue(2'd1, 32'h510e527f, 4'd4);
    @(negedge clk);
    chk("a_sum1", a_resp_data, 32'h3587272b);
    chk("a_sum1_id", a_resp_id, 4);
    a_issue(2'd2, 32'h00000001, 4'd5);
    @(negedge clk);
    chk("a_sig0_valid", a_resp_valid, 1);
    chk("a_sig0", a_resp_data, 32'h02004000);
    a_issue(2'd3, 32'h00000001, 4'd6);
    @(negedge clk);
    chk("a_sig1", a_resp_data, 32'h0000a000);
    chk("a_sig1_id", a_resp_id, 6);
    a_req_valid = 1'b0;
    @(negedge clk);
    chk("a_drain_valid", a_resp_valid, 0);
    chk("a_drain_busy", a_busy, 0);

    // b: three stages, fill then stall for 4 cycles
    b_resp_ready = 1'b0;
    b_issue(bf[0], bd[0], 4'd1);
    chk("b_ready_empty", b_req_ready, 1);
    @(negedge clk);
    chk("b_lat1_valid", b_resp_valid, 0);
    b_issue(bf[1], bd[1], 4'd2);
    @(negedge clk);
    chk("b_lat2_valid", b_resp_valid, 0);
    b_issue(bf[2], bd[2], 4'd3);
    @(negedge clk);
    b_issue(bf[3], bd[3], 4'd4);
    for (int k = 0; k < 4; k++) begin
      chk("b_stall_ready", b_req_ready, 0);
      chk("b_stall_valid", b_resp_valid, 1);
      chk("b_stall_data", b_resp_data, be[0]);
      chk("b_stall_id", b_resp_id, 1);
      chk("b_stall_busy", b_busy, 1);
      @(negedge clk);
    end
    b_resp_ready = 1'b1;
    #1;
    chk("b_unstall_ready", b_req_ready, 1);
    chk("b_unstall_data", b_resp_data, be[0]);
    @(negedge clk);
    b_issue(bf[4], bd[4], 4'd5);
    chk("b_out1", b_resp_data, be[1]);
    chk("b_out1_id", b_resp_id, 2);
    @(negedge clk);
    b_req_valid = 1'b0;
    for (int k = 2; k < 5; k++) begin
      chk("b_out_valid", b_resp_valid, 1);
      chk("b_out_data", b_resp_data, be[k]);
      chk("b_out_id", b_resp_id, k + 1);
      @(negedge clk);
    end
    chk("b_drained_valid", b_resp_valid, 0);
    chk("b_drained_busy", b_busy, 0);
`ifdef SHA2_SIGMA_CFU_PERF_EN
    chk("b_perf_req", b_perf_req, 5);
    chk("b_perf_stall", b_perf_stall, 4);
    chk("a_perf_req", a_perf_req, 4);
    chk("a_perf_stall", a_perf_stall, 0);
`endif

    // c: 64-bit, two stages
    c_resp_ready = 1'b1;
    c_req_valid = 1'b1; c_req_func = 2'd2; c_req_data0 = 64'h1; c_req_id = 4'd7;
    @(negedge clk);
    chk("c_lat1_valid", c_resp_valid, 0);
    c_req_func = 2'd3; c_req_id = 4'd8;
    @(negedge clk);
    c_req_valid = 1'b0;
    chk("c_sig0_valid", c_resp_valid, 1);
    chk("c_sig0", c_resp_data, 64'h8100000000000000);
    chk("c_sig0_id", c_resp_id, 7);
    @(negedge clk);
    chk("c_sig1", c_resp_data, 64'h0000200000000008);
    chk("c_sig1_id", c_resp_id, 8);
    @(negedge clk);
    chk("c_drain_valid", c_resp_valid, 0);

    // b: asynchronous reset with two entries in flight
    b_issue(2'd0, 32'h6a09e667, 4'd10);
    @(negedge clk);
    b_issue(2'd1, 32'h510e527f, 4'd11);
    @(negedge clk);
    b_req_valid = 1'b0;
    chk("b_inflight_busy", b_busy, 1);
    #1 rst = 1'b0;
    #1;
    chk("b_arst_valid", b_resp_valid, 0);
    chk("b_arst_busy", b_busy, 0);
    chk("b_arst_ready", b_req_ready, 0);
    chk("b_arst_data", b_resp_data, 0);
`ifdef SHA2_SIGMA_CFU_PERF_EN
    chk("b_arst_perf_req", b_perf_req, 0);
    chk("b_arst_perf_stall", b_perf_stall, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("b_no_stale_valid", b_resp_valid, 0);
      chk("b_no_stale_busy", b_busy, 0);
    end
    chk("b_rerun_ready", b_req_ready, 1);
    b_issue(2'd3, 32'h00000001, 4'd12);
    @(negedge clk);
    b_req_valid = 1'b0;
    chk("b_new_lat1", b_resp_valid, 0);
    @(negedge clk);
    chk("b_new_lat2", b_resp_valid, 0);
    @(negedge clk);
    chk("b_new_valid", b_resp_valid, 1);
    chk("b_new_data", b_resp_data, 32'h0000a000);
    chk("b_new_id", b_resp_id, 12);
    @(negedge clk);
    chk("b_new_drain", b_resp_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
